// File: rtl/mem_fifo_ctrl_pkg.sv
// mem_fifo_pkg: shared widths and FSM state encoding for the Memory_64byte FIFO controller.
//   DATA_W     - byte width of FIFO data and memory data buses
//   ADDR_W     - pointer width (64 entries)
//   MEM_ADDR_W - width of the memory address bus (upper bits tied to 0)
//   DEPTH      - number of FIFO entries, equal to the memory capacity
//   COUNT_W    - occupancy counter width (0..DEPTH)
package mem_fifo_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned DEPTH      = 64;
    localparam int unsigned COUNT_W    = 7;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_RD      = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// mem_fifo_ctrl_if: client handshake and memory-side bus of the FIFO controller.
//   Client side : PUSH/PUSH_DATA/PUSH_ACK, POP/POP_DATA/POP_VALID, FULL, EMPTY, COUNT, ERR
//   Memory side : MEM_D_IN, MEM_ADDR, MEM_R_ENABLE, MEM_W_ENABLE, MEM_D_OUT
//   modport slave  - the controller
//   modport master - the environment (client plus memory)
interface mem_fifo_ctrl_if;
    import mem_fifo_pkg::*;

    logic                  PUSH;
    logic [DATA_W-1:0]     PUSH_DATA;
    logic                  PUSH_ACK;
    logic                  POP;
    logic [DATA_W-1:0]     POP_DATA;
    logic                  POP_VALID;
    logic                  FULL;
    logic                  EMPTY;
    logic [COUNT_W-1:0]    COUNT;
    logic                  ERR;
    logic [DATA_W-1:0]     MEM_D_IN;
    logic [MEM_ADDR_W-1:0] MEM_ADDR;
    logic                  MEM_R_ENABLE;
    logic                  MEM_W_ENABLE;
    logic [DATA_W-1:0]     MEM_D_OUT;

    modport slave (
        input  PUSH, PUSH_DATA, POP, MEM_D_OUT,
        output PUSH_ACK, POP_DATA, POP_VALID, FULL, EMPTY, COUNT, ERR,
        output MEM_D_IN, MEM_ADDR, MEM_R_ENABLE, MEM_W_ENABLE
    );

    modport master (
        output PUSH, PUSH_DATA, POP, MEM_D_OUT,
        input  PUSH_ACK, POP_DATA, POP_VALID, FULL, EMPTY, COUNT, ERR,
        input  MEM_D_IN, MEM_ADDR, MEM_R_ENABLE, MEM_W_ENABLE
    );

endinterface

// File: rtl/mem_fifo_ctrl_fifo_ptr.sv
// fifo_ptr: ADDR_W-bit wrapping pointer (63 -> 0) with increment enable.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears the pointer
//   inc - advance the pointer by one this cycle
//   ptr - current pointer value
module fifo_ptr
    import mem_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: byte FIFO built on an external Memory_64byte (1-cycle read latency).
//   CLK   - rising-edge clock
//   RESET - asynchronous active-high reset
//   bus   - mem_fifo_ctrl_if.slave: client push/pop handshake, status, memory bus
// A push occupies IDLE+WR (PUSH_ACK two edges after PUSH is sampled); a pop
// occupies IDLE+RD+RD_WAIT (POP_VALID three edges after POP). All outputs are
// registered. Simultaneous valid push and pop alternate, pop first after reset.
// Optional: define MEM_FIFO_CTRL_ERR_EN to build the sticky ERR flag (push
// while FULL or pop while EMPTY seen in IDLE); otherwise ERR is tied to 0.
module mem_fifo_ctrl #(
    parameter int unsigned DEPTH = mem_fifo_pkg::DEPTH
) (
    input  logic           CLK,
    input  logic           RESET,
    mem_fifo_ctrl_if.slave bus
);
    import mem_fifo_pkg::*;

    localparam logic [COUNT_W-1:0] FULL_LEVEL = COUNT_W'(DEPTH);

    logic [1:0]         state;
    logic               prio_pop;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               wr_inc;
    logic               rd_inc;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_inc;
    logic [COUNT_W-1:0] count_dec;
    logic               full;
    logic               empty;
    logic               push_ack;
    logic               pop_valid;
    logic [DATA_W-1:0]  pop_data;
    logic [DATA_W-1:0]  mem_d_in;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_r_en;
    logic               mem_w_en;
    logic               err;
    logic               push_ok;
    logic               pop_ok;
    logic               grant_pop;
    logic               grant_push;

    // Pointers advance on the edge that leaves the data-moving state.
    assign wr_inc = (state == S_WR);
    assign rd_inc = (state == S_RD_WAIT);

    fifo_ptr u_wr_ptr (.clk(CLK), .rst(RESET), .inc(wr_inc), .ptr(wr_ptr));
    fifo_ptr u_rd_ptr (.clk(CLK), .rst(RESET), .inc(rd_inc), .ptr(rd_ptr));

    assign count_inc = count + 1'b1;
    assign count_dec = count - 1'b1;

    // FULL blocks the push and EMPTY blocks the pop, so a both-pending request
    // at FULL/EMPTY is not contested and never flips the priority toggle.
    always_comb begin
        push_ok    = bus.PUSH & ~full;
        pop_ok     = bus.POP & ~empty;
        grant_pop  = pop_ok & (~push_ok | prio_pop);
        grant_push = push_ok & ~grant_pop;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            prio_pop  <= 1'b1;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            push_ack  <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            mem_d_in  <= '0;
            mem_addr  <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
        end else begin
            push_ack  <= 1'b0;
            pop_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (push_ok && pop_ok) begin
                        prio_pop <= ~prio_pop;
                    end
                    if (grant_pop) begin
                        state    <= S_RD;
                        mem_r_en <= 1'b1;
                        mem_addr <= rd_ptr;
                    end else if (grant_push) begin
                        state    <= S_WR;
                        mem_w_en <= 1'b1;
                        mem_addr <= wr_ptr;
                        mem_d_in <= bus.PUSH_DATA;
                    end
                end
                S_WR: begin
                    state    <= S_IDLE;
                    mem_w_en <= 1'b0;
                    push_ack <= 1'b1;
                    count    <= count_inc;
                    full     <= (count_inc == FULL_LEVEL);
                    empty    <= 1'b0;
                end
                S_RD: begin
                    state    <= S_RD_WAIT;
                    mem_r_en <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    pop_data  <= bus.MEM_D_OUT;
                    pop_valid <= 1'b1;
                    count     <= count_dec;
                    empty     <= (count_dec == '0);
                    full      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_FIFO_CTRL_ERR_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err <= 1'b0;
        end else if ((state == S_IDLE) &&
                     ((bus.PUSH && full) || (bus.POP && empty))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign bus.PUSH_ACK     = push_ack;
    assign bus.POP_DATA     = pop_data;
    assign bus.POP_VALID    = pop_valid;
    assign bus.FULL         = full;
    assign bus.EMPTY        = empty;
    assign bus.COUNT        = count;
    assign bus.ERR          = err;
    assign bus.MEM_D_IN     = mem_d_in;
    assign bus.MEM_ADDR     = {{(MEM_ADDR_W - ADDR_W){1'b0}}, mem_addr};
    assign bus.MEM_R_ENABLE = mem_r_en;
    assign bus.MEM_W_ENABLE = mem_w_en;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: self-checking bench for mem_fifo_ctrl with a behavioural
// Memory_64byte model and a reference queue of expected pop data.
module tb_mem_fifo_ctrl;
    import mem_fifo_pkg::*;

`ifdef MEM_FIFO_CTRL_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_fifo_ctrl_if bus();

    mem_fifo_ctrl #(.DEPTH(64)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // Memory_64byte model: write on W_ENABLE, read data valid the next cycle.
    logic [7:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.MEM_W_ENABLE) mem[bus.MEM_ADDR[5:0]] <= bus.MEM_D_IN;
        if (bus.MEM_R_ENABLE) bus.MEM_D_OUT <= mem[bus.MEM_ADDR[5:0]];
    end

    logic en_clash    = 1'b0;
    logic addr_hi_bad = 1'b0;
    always @(negedge clk) begin
        if (bus.MEM_R_ENABLE && bus.MEM_W_ENABLE) en_clash <= 1'b1;
        if (bus.MEM_ADDR[7:6] != 2'b00) addr_hi_bad <= 1'b1;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q [$];
    int unsigned m_count;
    logic [5:0]  m_wr;
    logic [5:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.PUSH = 1'b0;
        bus.POP  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_wr    = '0;
        m_rd    = '0;
    endtask

    task automatic do_push(input logic [7:0] d);
        logic       expect_ack;
        logic       seen_ack;
        logic       wseen;
        logic [7:0] waddr;
        logic [7:0] wdata;
        int         lat;
        expect_ack = (m_count < 64);
        seen_ack   = 1'b0;
        wseen      = 1'b0;
        waddr      = 8'hFF;
        wdata      = 8'h00;
        lat        = 0;
        if (expect_ack) exp_q.push_back(d);
        @(negedge clk);
        bus.PUSH      = 1'b1;
        bus.PUSH_DATA = d;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.MEM_W_ENABLE) begin
                wseen = 1'b1;
                waddr = bus.MEM_ADDR;
                wdata = bus.MEM_D_IN;
            end
            if (bus.PUSH_ACK) begin
                seen_ack = 1'b1;
                lat      = c;
                break;
            end
        end
        bus.PUSH = 1'b0;
        if (expect_ack) begin
            check("push_ack_latency", lat, 2);
            check("push_mem_addr", waddr, {2'b00, m_wr});
            check("push_mem_data", wdata, d);
            m_count++;
            m_wr++;
            check("push_count", bus.COUNT, m_count);
        end else begin
            check("push_full_no_ack", seen_ack, 0);
            check("push_full_no_write", wseen, 0);
            check("push_full_err", bus.ERR, ERR_ON);
            check("push_full_count", bus.COUNT, m_count);
        end
    endtask

    task automatic do_pop();
        logic       expect_valid;
        logic       seen_valid;
        logic       rseen;
        logic [7:0] raddr;
        logic [7:0] rdata;
        logic [7:0] want;
        int         lat;
        expect_valid = (m_count > 0);
        seen_valid   = 1'b0;
        rseen        = 1'b0;
        raddr        = 8'hFF;
        rdata        = 8'h00;
        lat          = 0;
        @(negedge clk);
        bus.POP = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.MEM_R_ENABLE) begin
                rseen = 1'b1;
                raddr = bus.MEM_ADDR;
            end
            if (bus.POP_VALID) begin
                seen_valid = 1'b1;
                lat        = c;
                rdata      = bus.POP_DATA;
                break;
            end
        end
        bus.POP = 1'b0;
        if (expect_valid) begin
            want = exp_q.pop_front();
            check("pop_valid_latency", lat, 3);
            check("pop_mem_addr", raddr, {2'b00, m_rd});
            check("pop_data", rdata, want);
            m_count--;
            m_rd++;
            check("pop_count", bus.COUNT, m_count);
            check("pop_empty", bus.EMPTY, (m_count == 0));
        end else begin
            check("pop_empty_no_valid", seen_valid, 0);
            check("pop_empty_no_read", rseen, 0);
            check("pop_empty_err", bus.ERR, ERR_ON);
        end
    endtask

    task automatic contested();
        int         g;
        logic       kind;
        logic [7:0] cur;
        logic [7:0] want;
        logic       exp_kind [4];
        exp_kind[0] = 1'b1;
        exp_kind[1] = 1'b0;
        exp_kind[2] = 1'b1;
        exp_kind[3] = 1'b0;
        g   = 0;
        cur = 8'h60;
        @(negedge clk);
        bus.PUSH      = 1'b1;
        bus.PUSH_DATA = cur;
        bus.POP       = 1'b1;
        for (int c = 0; c < 40 && g < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.POP_VALID || bus.PUSH_ACK) begin
                kind = bus.POP_VALID;
                check("contest_order", kind, exp_kind[g]);
                if (bus.POP_VALID) begin
                    want = exp_q.pop_front();
                    check("contest_pop_data", bus.POP_DATA, want);
                    m_count--;
                    m_rd++;
                end else begin
                    exp_q.push_back(cur);
                    m_count++;
                    m_wr++;
                    cur           = cur + 8'd1;
                    bus.PUSH_DATA = cur;
                end
                check("contest_count", bus.COUNT, m_count);
                g++;
            end
        end
        bus.PUSH = 1'b0;
        bus.POP  = 1'b0;
        check("contest_grants", g, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        bus.PUSH      = 1'b0;
        bus.POP       = 1'b0;
        bus.PUSH_DATA = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        check("rst_count", bus.COUNT, 0);
        check("rst_empty", bus.EMPTY, 1);
        check("rst_full", bus.FULL, 0);
        check("rst_push_ack", bus.PUSH_ACK, 0);
        check("rst_pop_valid", bus.POP_VALID, 0);
        check("rst_r_en", bus.MEM_R_ENABLE, 0);
        check("rst_w_en", bus.MEM_W_ENABLE, 0);
        check("rst_err", bus.ERR, 0);
        check("rst_addr", bus.MEM_ADDR, 0);
        check("rst_d_in", bus.MEM_D_IN, 0);
        check("rst_pop_data", bus.POP_DATA, 0);
        do_reset();

        // Single push/pop, then pop on empty.
        do_push(8'h01);
        do_pop();
        do_pop();

        // Fill, reject overflow, partial drain, wrap-around refill, full drain.
        do_reset();
        for (int i = 0; i < 64; i++) do_push(8'(i));
        check("fill_full", bus.FULL, 1);
        check("fill_count", bus.COUNT, 64);
        do_push(8'hAA);
        for (int i = 0; i < 10; i++) do_pop();
        for (int i = 0; i < 10; i++) do_push(8'hC0 + 8'(i));
        check("wrap_full", bus.FULL, 1);
        for (int i = 0; i < 64; i++) do_pop();
        check("wrap_drain_empty", bus.EMPTY, 1);
        check("wrap_queue_left", exp_q.size(), 0);

        // Contested push/pop starting from COUNT=5.
        do_reset();
        for (int i = 0; i < 5; i++) do_push(8'h50 + 8'(i));
        contested();
        while (m_count > 0) do_pop();

        // Reset while a read is in flight.
        do_reset();
        do_push(8'h77);
        @(negedge clk);
        bus.POP = 1'b1;
        @(posedge clk);
        #1;
        check("rd_r_en_high", bus.MEM_R_ENABLE, 1);
        rst = 1'b1;
        #1;
        check("rd_rst_r_en", bus.MEM_R_ENABLE, 0);
        check("rd_rst_w_en", bus.MEM_W_ENABLE, 0);
        check("rd_rst_count", bus.COUNT, 0);
        check("rd_rst_empty", bus.EMPTY, 1);
        check("rd_rst_valid", bus.POP_VALID, 0);
        @(negedge clk);
        bus.POP = 1'b0;
        rst     = 1'b0;
        begin
            logic late_valid;
            late_valid = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (bus.POP_VALID) late_valid = 1'b1;
            end
            check("rd_rst_no_valid", late_valid, 0);
        end

        check("mem_en_exclusive", en_clash, 0);
        check("mem_addr_hi_zero", addr_hi_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
